// File: rtl/mbist_pkg.sv
// mbist_pkg: shared FSM states, March C- element table and op helper for the BIST engine.
package mbist_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  typedef struct packed {
    logic rwbar;
    logic pol;
  } op_t;
  localparam int NUM_ELEM = 6;
  // Bit e of each vector describes march element e.
  localparam logic [NUM_ELEM-1:0] ELEM_DOWN = 6'b011000;
  localparam logic [NUM_ELEM-1:0] ELEM_TWO  = 6'b011110;
  localparam logic [NUM_ELEM-1:0] OP0_RD    = 6'b111110;
  localparam logic [NUM_ELEM-1:0] OP0_POL   = 6'b010100;
  localparam logic [NUM_ELEM-1:0] OP1_POL   = 6'b001010;
  function automatic op_t elem_op(input logic [2:0] e, input logic second);
    op_t o;
    o.rwbar = second ? 1'b0 : OP0_RD[e];
    o.pol   = second ? OP1_POL[e] : OP0_POL[e];
    return o;
  endfunction
endpackage

// File: rtl/mbist_bg_gen.sv
// mbist_bg_gen: background index to data word; bg 0 is zeros, bit i of bg k is bit k-1 of i.
module mbist_bg_gen #(
  parameter int DATA_W = 8,
  parameter int BG_W   = 3
) (
  input  logic [BG_W-1:0]   bg_idx,
  output logic [DATA_W-1:0] bg_word
);
  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    localparam logic [31:0] IV = 32'(i);
    assign bg_word[i] = (bg_idx != '0) && IV[5'(bg_idx - 1'b1)];
  end
endmodule

// File: rtl/mbist_march_engine.sv
// mbist_march_engine: March C- BIST sequencer over all backgrounds with pipelined compare,
// first-fail capture, saturating fail count and functional/BIST SRAM port mux.
module mbist_march_engine
  import mbist_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8,
  parameter int NUM_BG = 4,
  parameter int CNT_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      func_cs,
  input  logic                      func_rwbar,
  input  logic [ADDR_W-1:0]         func_addr,
  input  logic [DATA_W-1:0]         func_wdata,
  output logic                      mem_cs,
  output logic                      mem_rwbar,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [CNT_W-1:0]          fail_cnt,
  output logic [ADDR_W-1:0]         fail_addr,
  output logic [DATA_W-1:0]         fail_exp,
  output logic [DATA_W-1:0]         fail_act,
  output logic [2:0]                fail_elem,
  output logic [$clog2(NUM_BG):0]   fail_bg
);
  localparam int BG_W = $clog2(NUM_BG) + 1;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, cmp_addr_q, cmp_addr_d, fail_addr_q, fail_addr_d;
  logic [2:0] elem_q, elem_d, elem_nx, cmp_elem_q, cmp_elem_d, fail_elem_q, fail_elem_d;
  logic [BG_W-1:0] bg_q, bg_d, cmp_bg_q, cmp_bg_d, fail_bg_q, fail_bg_d;
  logic [DATA_W-1:0] bg_word, exp_word, cmp_exp_q, cmp_exp_d, fail_exp_q, fail_exp_d, fail_act_q, fail_act_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic op_q, op_d, cmp_vld_q, cmp_vld_d;
  logic down, last_op, last_addr, last_elem, last_bg, final_op, go, step, adv, miscmp, first;
  op_t op;
  mbist_bg_gen #(.DATA_W(DATA_W), .BG_W(BG_W)) u_bg (.bg_idx(bg_q), .bg_word(bg_word));
  always_comb begin
    op        = elem_op(elem_q, op_q);
    down      = ELEM_DOWN[elem_q];
    last_op   = op_q || !ELEM_TWO[elem_q];
    last_addr = addr_q == {ADDR_W{!down}};
    last_elem = elem_q == 3'(NUM_ELEM - 1);
    last_bg   = bg_q == BG_W'(NUM_BG - 1);
    final_op  = last_op && last_addr && last_elem && last_bg;
    elem_nx   = last_elem ? 3'd0 : elem_q + 3'd1;
    exp_word  = op.pol ? ~bg_word : bg_word;
    go        = start && !abort && (state_q == IDLE || state_q == DONE);
    step      = state_q == RUN && !abort;
    adv       = step && last_op && last_addr;
  end
  always_comb begin
    op_d        = step && !last_op;
    addr_d      = go ? '0 : !step || !last_op ? addr_q : !last_addr ? (down ? addr_q - 1'b1 : addr_q + 1'b1)
                : {ADDR_W{ELEM_DOWN[elem_nx]}};
    elem_d      = go ? '0 : adv ? elem_nx : elem_q;
    bg_d        = go ? '0 : adv && last_elem ? bg_q + 1'b1 : bg_q;
    cmp_vld_d   = step && op.rwbar;
    cmp_exp_d   = exp_word;
    cmp_addr_d  = addr_q;
    cmp_elem_d  = elem_q;
    cmp_bg_d    = bg_q;
    // An abort discards the compare that would have landed on that edge.
    miscmp      = cmp_vld_q && !abort && (mem_rdata != cmp_exp_q);
    first       = miscmp && fail_cnt_q == '0;
    fail_cnt_d  = go ? '0 : miscmp && fail_cnt_q != '1 ? fail_cnt_q + 1'b1 : fail_cnt_q;
    fail_addr_d = go ? '0 : first ? cmp_addr_q : fail_addr_q;
    fail_exp_d  = go ? '0 : first ? cmp_exp_q : fail_exp_q;
    fail_act_d  = go ? '0 : first ? mem_rdata : fail_act_q;
    fail_elem_d = go ? '0 : first ? cmp_elem_q : fail_elem_q;
    fail_bg_d   = go ? '0 : first ? cmp_bg_q : fail_bg_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = go ? RUN
            : (state_q == RUN || state_q == DRAIN) && abort ? IDLE
            : state_q == RUN && final_op ? DRAIN
            : state_q == DRAIN ? DONE
            : state_q;
  end
  always_comb begin
    busy      = state_q == RUN || state_q == DRAIN;
    done      = state_q == DONE;
    pass      = done && fail_cnt_q == '0;
    mem_cs    = busy ? state_q == RUN : func_cs;
    mem_rwbar = busy ? op.rwbar || state_q == DRAIN : func_rwbar;
    mem_addr  = busy ? addr_q : func_addr;
    mem_wdata = busy ? exp_word : func_wdata;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      elem_q      <= '0;
      bg_q        <= '0;
      op_q        <= 1'b0;
      cmp_vld_q   <= 1'b0;
      cmp_exp_q   <= '0;
      cmp_addr_q  <= '0;
      cmp_elem_q  <= '0;
      cmp_bg_q    <= '0;
      fail_cnt_q  <= '0;
      fail_addr_q <= '0;
      fail_exp_q  <= '0;
      fail_act_q  <= '0;
      fail_elem_q <= '0;
      fail_bg_q   <= '0;
    end else begin
      addr_q      <= addr_d;
      elem_q      <= elem_d;
      bg_q        <= bg_d;
      op_q        <= op_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_exp_q   <= cmp_exp_d;
      cmp_addr_q  <= cmp_addr_d;
      cmp_elem_q  <= cmp_elem_d;
      cmp_bg_q    <= cmp_bg_d;
      fail_cnt_q  <= fail_cnt_d;
      fail_addr_q <= fail_addr_d;
      fail_exp_q  <= fail_exp_d;
      fail_act_q  <= fail_act_d;
      fail_elem_q <= fail_elem_d;
      fail_bg_q   <= fail_bg_d;
    end
  end
  assign fail_cnt  = fail_cnt_q;
  assign fail_addr = fail_addr_q;
  assign fail_exp  = fail_exp_q;
  assign fail_act  = fail_act_q;
  assign fail_elem = fail_elem_q;
  assign fail_bg   = fail_bg_q;
endmodule
